aq_fifo_sync_ctrl: RTL and testbench
====================================

Name: aq_fifo_sync_ctrl

Overview:
- Single-clock, first-word-fall-through FIFO controller that sequences one aq_fifo_ram instance.
- Owns write/read pointers, the full/empty/level flags, and the RAM address and enable drive.
- Hides the RAM's one-cycle registered read behind a valid/ready stream interface on both sides.
- Used wherever a same-clock elastic buffer sits between AXI-stream-style producers and consumers.

Parameters:
- DEPTH, 8: RAM address bits; capacity is 2**DEPTH words.
- WIDTH, 32: data width.
- AFULL_LEVEL, 2**DEPTH-2: ALMOST_FULL asserts when COUNT >= this value.
- AEMPTY_LEVEL, 2: ALMOST_EMPTY asserts when COUNT <= this value.

Ports:
- CLK  in  1  sole clock. One clock; reset is asynchronous and active-low.
- RST_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  synchronous flush, active-high.
- S_VALID  in  1  write request.
- S_READY  out  1  write accept.
- S_DATA  in  WIDTH  write data.
- M_VALID  out  1  read data valid.
- M_READY  in  1  read accept.
- M_DATA  out  WIDTH  head-of-FIFO data.
- COUNT  out  DEPTH+1  occupancy.
- FULL  out  1  COUNT == 2**DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  level flag.
- ALMOST_EMPTY  out  1  level flag.

Behaviour:
- Registers:
  - wr_ptr, rd_ptr, wr_ptr_d: each DEPTH+1 bits, with the MSB as the wrap bit.
  - All reset asynchronously to 0 on RST_N low.
- Push:
  - push = S_VALID & S_READY.
  - S_READY = !FULL. It does not depend on M_READY, so a push is refused when full even if a pop occurs in the same cycle.
  - On push: WR_ENA=1, WR_ADRS=wr_ptr[DEPTH-1:0], WR_DATA=S_DATA, wr_ptr+1.
- Visibility pipeline:
  - wr_ptr_d <= wr_ptr every cycle.
  - M_VALID = (rd_ptr != wr_ptr_d).
  - A word pushed at edge t gives M_VALID high after edge t+1. First-word latency is 2 cycles.
- Pop and read addressing:
  - pop = M_VALID & M_READY; rd_ptr+1 on pop.
  - RD_ADRS = (pop ? rd_ptr+1 : rd_ptr)[DEPTH-1:0]. The RAM read register therefore always holds ram[rd_ptr] after each edge.
  - M_DATA = RD_DATA directly, with no extra register.
  - Sustained throughput is 1 push and 1 pop per cycle.
- Arithmetic:
  - COUNT = wr_ptr - rd_ptr, modulo 2**(DEPTH+1). This includes words not yet visible.
  - EMPTY = (COUNT == 0) while M_VALID lags, so EMPTY=0 with M_VALID=0 is legal for one cycle.
  - FULL = (COUNT == 2**DEPTH). Flags are combinational from registers.
- Wrap-around: pointers wrap naturally, with the MSB distinguishing full from empty at equal low bits.
- CLEAR:
  - At the edge, all three pointers go to 0, and any same-cycle push/pop is discarded (WR_ENA forced 0).
  - RD_ADRS=0 during CLEAR.
  - After CLEAR: EMPTY=1, M_VALID=0, S_READY=1.
- Reset values: S_READY=1, M_VALID=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
- M_DATA is undefined (the RAM is not reset) and is meaningful only while M_VALID=1.
- Reset mid-operation: contents are abandoned and pointers zeroed immediately (asynchronous). No partial word appears on M_* afterwards.
- Protocol rules:
  - M_VALID/M_DATA are stable while M_VALID & !M_READY.
  - The controller never deasserts M_VALID without a pop or CLEAR.

Decomposition:
- Sub-module: aq_fifo_ram, instantiated with WR_CLK=RD_CLK=CLK.
- Shared package aq_fifo_pkg:
  - pointer-width helper localparam function (DEPTH+1);
  - default level constants;
  - no structs, since the stream is flat.
- Pointer and flag logic stays in this module. No further sub-module.

Test Plan:
- All tests use DEPTH=2 (4 words), WIDTH=8, AFULL_LEVEL=3, AEMPTY_LEVEL=1.
- Reset release, push 0xA1 at edge 1, M_READY=0 -> M_VALID=1 after edge 2, M_DATA=0xA1, COUNT=1, ALMOST_EMPTY=1; holds while M_READY=0.
- Push 0x10..0x13 back-to-back -> after 4th, FULL=1, S_READY=0, COUNT=4, ALMOST_FULL=1; 5th S_VALID ignored; pops return 0x10,0x11,0x12,0x13 in order, then M_VALID=0, EMPTY=1.
- Steady state with COUNT=2, S_VALID=M_READY=1 for 10 cycles, data 0x20..0x29 -> COUNT stays 2, output sequence contiguous, pointers wrap twice with no gap or repeat.
- Full FIFO, S_VALID=1 and M_READY=1 same cycle -> push refused (S_READY=0), one pop, COUNT=3; next cycle push accepted, COUNT=4.
- COUNT=3 with push and pop asserted together with CLEAR -> after edge COUNT=0, EMPTY=1, M_VALID=0; subsequent push 0x55 emerges 2 cycles later as the only word.
- RST_N asserted asynchronously mid-stream with COUNT=2 -> flags immediately at reset values; after release, push 0x77 -> only 0x77 read out.

Source files
------------

// File: rtl/aq_fifo_pkg.sv
// rtl/aq_fifo_pkg.sv - shared constants and helpers for the aq_fifo family
package aq_fifo_pkg;

    localparam int DEFAULT_DEPTH        = 8;
    localparam int DEFAULT_WIDTH        = 32;
    localparam int DEFAULT_AEMPTY_LEVEL = 2;

    // Pointers carry one extra wrap bit so full and empty differ at equal low bits.
    function automatic int ptr_width(input int depth);
        return depth + 1;
    endfunction

    function automatic int default_afull_level(input int depth);
        return (1 << depth) - 2;
    endfunction

endpackage

// File: rtl/aq_fifo_sync_ctrl_if.sv
// rtl/aq_fifo_sync_ctrl_if.sv - valid/ready write and read streams of the sync FIFO
interface aq_fifo_sync_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             S_VALID;
    logic             S_READY;
    logic [WIDTH-1:0] S_DATA;
    logic             M_VALID;
    logic             M_READY;
    logic [WIDTH-1:0] M_DATA;

    modport master (
        output S_VALID, S_DATA, M_READY,
        input  S_READY, M_VALID, M_DATA
    );

    modport slave (
        input  S_VALID, S_DATA, M_READY,
        output S_READY, M_VALID, M_DATA
    );
endinterface

// File: rtl/aq_fifo_ram.sv
// rtl/aq_fifo_ram.sv - simple dual-port RAM with a registered read, contents not reset
module aq_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             WR_CLK,
    input  logic             WR_ENA,
    input  logic [DEPTH-1:0] WR_ADRS,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_CLK,
    input  logic [DEPTH-1:0] RD_ADRS,
    output logic [WIDTH-1:0] RD_DATA
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge WR_CLK) begin
        if (WR_ENA) begin
            mem[WR_ADRS] <= WR_DATA;
        end
    end

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge RD_CLK) begin
        RD_DATA <= mem[RD_ADRS];
    end

endmodule

// File: rtl/aq_fifo_sync_ctrl.sv
// rtl/aq_fifo_sync_ctrl.sv - single-clock first-word-fall-through FIFO controller around aq_fifo_ram
module aq_fifo_sync_ctrl
    import aq_fifo_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int AFULL_LEVEL  = default_afull_level(DEPTH),
    parameter int AEMPTY_LEVEL = DEFAULT_AEMPTY_LEVEL
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    aq_fifo_sync_ctrl_if.slave bus,
    output logic [DEPTH:0]    COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY
);

    localparam int             PW       = ptr_width(DEPTH);
    localparam logic [PW-1:0]  CAPACITY = PW'(1) << DEPTH;
    localparam logic [PW-1:0]  AFULL_L  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0]  AEMPTY_L = PW'(AEMPTY_LEVEL);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             push;
    logic             pop;
    logic             wr_ena;
    logic [DEPTH-1:0] rd_adrs;

    assign COUNT        = wr_ptr - rd_ptr;
    assign FULL         = (COUNT == CAPACITY);
    assign EMPTY        = (COUNT == '0);
    assign ALMOST_FULL  = (COUNT >= AFULL_L);
    assign ALMOST_EMPTY = (COUNT <= AEMPTY_L);

    // Refusal when full is independent of M_READY to keep S_READY off the read path.
    assign bus.S_READY = !FULL;
    // A word becomes visible only once the RAM read register can hold it.
    assign bus.M_VALID = (rd_ptr != wr_ptr_d);

    assign push = bus.S_VALID & bus.S_READY;
    assign pop  = bus.M_VALID & bus.M_READY;

    assign wr_ena     = push & !CLEAR;
    assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    // Prefetch the next head so the read register always tracks ram[rd_ptr].
    assign rd_adrs    = CLEAR ? '0 : rd_ptr_nxt[DEPTH-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ptr_d <= '0;
        end else if (CLEAR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ptr_d <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr_d <= wr_ptr;
        end
    end

    aq_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .WR_CLK  (CLK),
        .WR_ENA  (wr_ena),
        .WR_ADRS (wr_ptr[DEPTH-1:0]),
        .WR_DATA (bus.S_DATA),
        .RD_CLK  (CLK),
        .RD_ADRS (rd_adrs),
        .RD_DATA (bus.M_DATA)
    );

endmodule

// File: tb/tb_aq_fifo_sync_ctrl.sv
// tb/tb_aq_fifo_sync_ctrl.sv - directed self-checking bench for aq_fifo_sync_ctrl
module tb_aq_fifo_sync_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;

    int n_cmp;
    int n_err;

    aq_fifo_sync_ctrl_if #(.WIDTH(8)) bus ();

    aq_fifo_sync_ctrl #(
        .DEPTH        (2),
        .WIDTH        (8),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .CLEAR        (clear),
        .bus          (bus),
        .COUNT        (count),
        .FULL         (full),
        .EMPTY        (empty),
        .ALMOST_FULL  (almost_full),
        .ALMOST_EMPTY (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.S_VALID = 1'b1;
        bus.S_DATA  = d;
        step();
        bus.S_VALID = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [7:0] d);
        chk({tag, "_valid"}, {31'd0, bus.M_VALID}, 32'd1);
        chk({tag, "_data"}, {24'd0, bus.M_DATA}, {24'd0, d});
        bus.M_READY = 1'b1;
        step();
        bus.M_READY = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, {29'd0, count}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_mvalid"}, {31'd0, bus.M_VALID}, 32'd0);
        chk({tag, "_sready"}, {31'd0, bus.S_READY}, 32'd1);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        bus.S_VALID = 1'b0;
        bus.S_DATA  = 8'h00;
        bus.M_READY = 1'b0;
        repeat (3) step();

        // Reset state
        chk_idle("rst");
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
        chk("rst_afull", {31'd0, almost_full}, 32'd0);
        rst_n = 1'b1;

        // First-word latency and hold while M_READY=0
        push_word(8'hA1);
        chk("t1_count_e1", {29'd0, count}, 32'd1);
        chk("t1_empty_e1", {31'd0, empty}, 32'd0);
        chk("t1_mvalid_e1", {31'd0, bus.M_VALID}, 32'd0);
        step();
        chk("t1_mvalid_e2", {31'd0, bus.M_VALID}, 32'd1);
        chk("t1_mdata_e2", {24'd0, bus.M_DATA}, 32'hA1);
        chk("t1_aempty", {31'd0, almost_empty}, 32'd1);
        step();
        step();
        chk("t1_hold_count", {29'd0, count}, 32'd1);
        pop_word("t1_hold", 8'hA1);
        chk_idle("t1_done");

        // Fill to full, refuse fifth, drain in order
        for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_sready", {31'd0, bus.S_READY}, 32'd0);
        chk("t2_count", {29'd0, count}, 32'd4);
        chk("t2_afull", {31'd0, almost_full}, 32'd1);
        push_word(8'h14);
        chk("t2_count_refused", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_word("t2_pop", 8'h10 + 8'(i));
        chk("t2_mvalid_end", {31'd0, bus.M_VALID}, 32'd0);
        chk("t2_empty_end", {31'd0, empty}, 32'd1);

        // Steady state at COUNT=2, simultaneous push/pop across two wraps
        push_word(8'h1E);
        push_word(8'h1F);
        step();
        bus.M_READY = 1'b1;
        bus.S_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.S_DATA = 8'h20 + 8'(i);
            chk("t3_mvalid", {31'd0, bus.M_VALID}, 32'd1);
            chk("t3_mdata", {24'd0, bus.M_DATA}, {24'd0, 8'h1E + 8'(i)});
            chk("t3_count", {29'd0, count}, 32'd2);
            step();
        end
        bus.S_VALID = 1'b0;
        bus.M_READY = 1'b0;
        pop_word("t3_tail", 8'h28);
        pop_word("t3_tail", 8'h29);
        chk_idle("t3_done");

        // Full with push and pop together: push refused, pop taken
        for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
        step();
        bus.S_VALID = 1'b1;
        bus.S_DATA  = 8'h34;
        bus.M_READY = 1'b1;
        chk("t4_sready_full", {31'd0, bus.S_READY}, 32'd0);
        chk("t4_head", {24'd0, bus.M_DATA}, 32'h30);
        step();
        bus.M_READY = 1'b0;
        chk("t4_count_after_pop", {29'd0, count}, 32'd3);
        chk("t4_sready_after", {31'd0, bus.S_READY}, 32'd1);
        step();
        bus.S_VALID = 1'b0;
        chk("t4_count_refill", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_word("t4_pop", 8'h31 + 8'(i));
        chk_idle("t4_done");

        // CLEAR wins over simultaneous push and pop
        push_word(8'h40);
        push_word(8'h41);
        push_word(8'h42);
        step();
        chk("t5_count_pre", {29'd0, count}, 32'd3);
        bus.S_VALID = 1'b1;
        bus.S_DATA  = 8'h43;
        bus.M_READY = 1'b1;
        clear       = 1'b1;
        step();
        clear       = 1'b0;
        bus.S_VALID = 1'b0;
        bus.M_READY = 1'b0;
        chk_idle("t5_clear");
        push_word(8'h55);
        chk("t5_mvalid_e1", {31'd0, bus.M_VALID}, 32'd0);
        step();
        chk("t5_count_55", {29'd0, count}, 32'd1);
        pop_word("t5_only", 8'h55);
        chk_idle("t5_done");

        // Asynchronous reset mid-stream
        push_word(8'h60);
        push_word(8'h61);
        step();
        chk("t6_count_pre", {29'd0, count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("t6_async");
        chk("t6_aempty", {31'd0, almost_empty}, 32'd1);
        chk("t6_full", {31'd0, full}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        push_word(8'h77);
        step();
        pop_word("t6_only", 8'h77);
        chk_idle("t6_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
